// File: rtl/dwconv_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : dwconv_sequencer_if
// Brief    : Control/issue bundle between the layer FSM and the depthwise-conv
//            issue sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface dwconv_sequencer_if #(
    parameter int CNT_W  = 5,
    parameter int POS_W  = 4,
    parameter int ADDR_W = 9
);
    logic              start;
    logic              clear;
    logic              stall;
    logic              en;
    logic [CNT_W-1:0]  cnt_out;
    logic [POS_W-1:0]  pos_out;
    logic [ADDR_W-1:0] fb_addr;
    logic [CNT_W-1:0]  w_addr;
    logic              busy;
    logic              out_valid;
    logic [POS_W-1:0]  out_pos;
    logic              done;

    modport master (
        output start, clear, stall,
        input  en, cnt_out, pos_out, fb_addr, w_addr, busy, out_valid, out_pos, done
    );

    modport slave (
        input  start, clear, stall,
        output en, cnt_out, pos_out, fb_addr, w_addr, busy, out_valid, out_pos, done
    );
endinterface
`default_nettype wire

// File: rtl/dwconv_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : dwconv_sequencer
// Brief    : Walks POS positions x CH channels for the DWconv datapath, tags
//            each position's last channel and pulses done after drain.
// Revision : 1.0 - initial release
// ============================================================================
module dwconv_sequencer #(
    parameter int CH       = 32,
    parameter int POS      = 9,
    parameter int PIPE_LAT = 4
) (
    input  wire                    clk,
    input  wire                    rst_b,
    dwconv_sequencer_if.slave      bus
);
    localparam int CNT_W  = $clog2(CH);
    localparam int POS_W  = 4;
    localparam int ADDR_W = $clog2(CH * POS);
    localparam int DRN_W  = (PIPE_LAT > 2) ? $clog2(PIPE_LAT - 1) : 1;
    localparam logic [POS_W-1:0] c_pos_bubble = '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [POS_W-1:0]  r_pos;
    logic [ADDR_W-1:0] r_fb;
    logic [DRN_W-1:0]  r_drain;
    logic [PIPE_LAT-2:0] r_tag_v;
    logic [POS_W-1:0]  r_tag_pos [PIPE_LAT];
    logic              r_out_valid;
    logic              r_done;

    logic w_en;
    logic w_last_ch;
    logic w_last_pos;

    assign w_en       = (r_state == ST_ISSUE || r_state == ST_DRAIN) && !bus.stall && !bus.clear;
    assign w_last_ch  = (r_cnt == CNT_W'(CH - 1));
    assign w_last_pos = (r_pos == POS_W'(POS - 1));

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_pos       <= '0;
            r_fb        <= '0;
            r_drain     <= '0;
            r_tag_v     <= '0;
            for (int i = 0; i < PIPE_LAT; i++) r_tag_pos[i] <= '0;
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
        end else if (bus.clear) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_pos       <= '0;
            r_fb        <= '0;
            r_drain     <= '0;
            r_tag_v     <= '0;
            for (int i = 0; i < PIPE_LAT; i++) r_tag_pos[i] <= '0;
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            // The tag reaching the last slot on this edge is what out_valid reports.
            r_out_valid <= w_en && r_tag_v[PIPE_LAT-2];
            r_done      <= 1'b0;

            if (w_en) begin
                r_tag_v[0]   <= (r_state == ST_ISSUE) && w_last_ch;
                r_tag_pos[0] <= r_pos;
                for (int i = 1; i < PIPE_LAT - 1; i++) r_tag_v[i] <= r_tag_v[i-1];
                for (int i = 1; i < PIPE_LAT; i++) r_tag_pos[i] <= r_tag_pos[i-1];
            end

            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_state <= ST_ISSUE;
                        r_cnt   <= '0;
                        r_pos   <= '0;
                        r_fb    <= '0;
                        r_drain <= '0;
                    end
                end
                ST_ISSUE: begin
                    if (w_en) begin
                        r_fb <= r_fb + ADDR_W'(1);
                        if (w_last_ch) begin
                            r_cnt <= '0;
                            if (w_last_pos) begin
                                r_state <= ST_DRAIN;
                                r_pos   <= c_pos_bubble;
                            end else begin
                                r_pos <= r_pos + POS_W'(1);
                            end
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_en) begin
                        if (r_drain == DRN_W'(PIPE_LAT - 2)) begin
                            r_state <= ST_IDLE;
                            r_done  <= 1'b1;
                            r_drain <= '0;
                            r_pos   <= '0;
                            r_fb    <= '0;
                        end else begin
                            r_drain <= r_drain + DRN_W'(1);
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.en        = w_en;
    assign bus.cnt_out   = r_cnt;
    assign bus.pos_out   = r_pos;
    assign bus.fb_addr   = r_fb;
    assign bus.w_addr    = r_cnt;
    assign bus.busy      = (r_state != ST_IDLE);
    assign bus.out_valid = r_out_valid;
    assign bus.out_pos   = r_tag_pos[PIPE_LAT-1];
    assign bus.done      = r_done;
endmodule
`default_nettype wire
